// File: rtl/present_sbox_layer_if.sv
// Valid/ready bundle for the PRESENT S-box layer.
// slave: the S-box layer; master: the word source / result sink.
interface present_sbox_layer_if #(
    parameter int WIDTH = 64
);
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             busy;

    modport slave (
        input  in_valid, in_mode, in_data, out_ready,
        output in_ready, out_valid, out_data, busy
    );

    modport master (
        output in_valid, in_mode, in_data, out_ready,
        input  in_ready, out_valid, out_data, busy
    );
endinterface

// File: rtl/present_sbox_layer.sv
// PRESENT S-box layer, LANES nibbles substituted per clock (fwd/inverse).
// Ports: clk, reset_n (async, active-low), bus (slave: in_*/out_*/busy).
module present_sbox_layer #(
    parameter int WIDTH = 64,
    parameter int LANES = 4
) (
    input  logic                   clk,
    input  logic                   reset_n,
    present_sbox_layer_if.slave    bus
);
    localparam int NIB   = WIDTH / 4;
    localparam int STEPS = NIB / LANES;
    localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS - 1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t           st;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] sub;
    logic [CW-1:0]    step;
    logic             mode;

    function automatic logic [3:0] fwd(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] inv(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            default: y = 4'hA;
        endcase
        return y;
    endfunction

    // Substitute only the LANES nibbles selected by the current step.
    always_comb begin
        sub = sr;
        for (int l = 0; l < LANES; l++) begin
            int idx;
            idx = int'(step) * LANES + l;
            sub[idx*4 +: 4] = mode ? inv(sr[idx*4 +: 4])
                                   : fwd(sr[idx*4 +: 4]);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st   <= IDLE;
            sr   <= '0;
            step <= '0;
            mode <= 1'b0;
        end else begin
            case (st)
                IDLE: begin
                    if (bus.in_valid) begin
                        sr   <= bus.in_data;
                        mode <= bus.in_mode;
                        step <= '0;
                        st   <= BUSY;
                    end
                end
                BUSY: begin
                    sr <= sub;
                    if (step == LAST) begin
                        st <= DONE;
                    end else begin
                        step <= step + CW'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        st <= IDLE;
                    end
                end
                default: st <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (st == IDLE);
    assign bus.out_valid = (st == DONE);
    assign bus.busy      = (st != IDLE);
    assign bus.out_data  = sr;

endmodule

// File: tb/tb_present_sbox_layer.sv
// Testbench for present_sbox_layer: LANES=4 main instance plus LANES=16
// and LANES=1 instances sharing the same input/ready stimulus.
module tb_present_sbox_layer;
    localparam logic [63:0] FWD_T = 64'h21748FE3DA09B65C;
    localparam logic [63:0] INV_T = 64'hA970364BD21C8FE5;

    logic        clk;
    logic        reset_n;
    logic        iv;
    logic        im;
    logic        ordy;
    logic [63:0] id;

    int n_chk;
    int n_fail;

    present_sbox_layer_if #(.WIDTH(64)) b4  ();
    present_sbox_layer_if #(.WIDTH(64)) b16 ();
    present_sbox_layer_if #(.WIDTH(64)) b1  ();

    assign b4.in_valid   = iv;
    assign b4.in_mode    = im;
    assign b4.in_data    = id;
    assign b4.out_ready  = ordy;
    assign b16.in_valid  = iv;
    assign b16.in_mode   = im;
    assign b16.in_data   = id;
    assign b16.out_ready = ordy;
    assign b1.in_valid   = iv;
    assign b1.in_mode    = im;
    assign b1.in_data    = id;
    assign b1.out_ready  = ordy;

    present_sbox_layer #(.WIDTH(64), .LANES(4)) dut4 (
        .clk(clk), .reset_n(reset_n), .bus(b4.slave)
    );
    present_sbox_layer #(.WIDTH(64), .LANES(16)) dut16 (
        .clk(clk), .reset_n(reset_n), .bus(b16.slave)
    );
    present_sbox_layer #(.WIDTH(64), .LANES(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .bus(b1.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic        m;
        logic [63:0] e;
    } vec_t;

    function automatic logic [63:0] model(input logic [63:0] d,
                                          input logic m);
        logic [63:0] t;
        logic [63:0] r;
        t = m ? INV_T : FWD_T;
        r = '0;
        for (int k = 0; k < 16; k++) begin
            r[k*4 +: 4] = t[d[k*4 +: 4]*4 +: 4];
        end
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic wait_idle_all();
        int n;
        n = 0;
        ordy = 1'b1;
        while (!(b4.in_ready && b16.in_ready && b1.in_ready) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        chk("idle wait", {63'd0, b4.in_ready && b16.in_ready && b1.in_ready},
            64'd1);
    endtask

    // One word through the LANES=4 instance with out_ready held high.
    task automatic run_word(input logic [63:0] d, input logic m,
                            output logic [63:0] r, output int lat);
        int  stray;
        bit  ok;
        wait_idle_all();
        iv = 1'b1;
        id = d;
        im = m;
        @(posedge clk); #1;
        iv = 1'b0;
        id = {$urandom, $urandom};
        im = 1'($urandom_range(0, 1));
        stray = 0;
        ok = 1'b0;
        lat = 0;
        for (int c = 1; c <= 40 && !ok; c++) begin
            if (b4.in_ready) stray++;
            @(posedge clk); #1;
            if (b4.out_valid) begin
                ok = 1'b1;
                lat = c;
            end
        end
        if (b4.in_ready) stray++;
        chk("out_valid timeout", {63'd0, ok}, 64'd1);
        chk("in_ready low busy/done", 64'(stray), 64'd0);
        r = b4.out_data;
        @(posedge clk); #1;
        chk("in_ready after out hs", {63'd0, b4.in_ready}, 64'd1);
        chk("out_valid after out hs", {63'd0, b4.out_valid}, 64'd0);
    endtask

    vec_t        vt[7];
    logic [63:0] res;
    logic [63:0] r0;
    int          lat;
    int          bad;
    int          l4, l16, l1;
    logic [63:0] q[$];
    int          sent, got;
    bit          acc;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset_n = 1'b0;
        iv = 1'b0;
        im = 1'b0;
        ordy = 1'b0;
        id = '0;

        vt[0] = '{64'h0123456789ABCDEF, 1'b0, 64'hC56B90AD3EF84712};
        vt[1] = '{64'hC56B90AD3EF84712, 1'b1, 64'h0123456789ABCDEF};
        vt[2] = '{64'h0000000000000000, 1'b0, 64'hCCCCCCCCCCCCCCCC};
        vt[3] = '{64'hFFFFFFFFFFFFFFFF, 1'b0, 64'h2222222222222222};
        vt[4] = '{64'h0000000000000000, 1'b1, 64'h5555555555555555};
        vt[5] = '{64'hFFFFFFFFFFFFFFFF, 1'b1, 64'hAAAAAAAAAAAAAAAA};
        vt[6] = '{64'hFEDCBA9876543210, 1'b0, 64'h21748FE3DA09B65C};

        #23 reset_n = 1'b1;
        @(posedge clk); #1;
        chk("rst in_ready", {63'd0, b4.in_ready}, 64'd1);
        chk("rst out_valid", {63'd0, b4.out_valid}, 64'd0);
        chk("rst busy", {63'd0, b4.busy}, 64'd0);
        chk("rst out_data", b4.out_data, 64'd0);
        chk("rst out_data l16", b16.out_data, 64'd0);
        chk("rst out_data l1", b1.out_data, 64'd0);

        for (int i = 0; i < 7; i++) begin
            run_word(vt[i].d, vt[i].m, res, lat);
            chk($sformatf("vec%0d data", i), res, vt[i].e);
            chk($sformatf("vec%0d latency", i), 64'(lat), 64'd4);
        end

        // All-zero word through every lane count at once.
        wait_idle_all();
        ordy = 1'b0;
        iv = 1'b1;
        id = '0;
        im = 1'b0;
        @(posedge clk); #1;
        iv = 1'b0;
        id = 64'h123456789ABCDEF0;
        l4 = 0;
        l16 = 0;
        l1 = 0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (l4 == 0 && b4.out_valid) l4 = c;
            if (l16 == 0 && b16.out_valid) l16 = c;
            if (l1 == 0 && b1.out_valid) l1 = c;
        end
        chk("lat lanes4", 64'(l4), 64'd4);
        chk("lat lanes16", 64'(l16), 64'd1);
        chk("lat lanes1", 64'(l1), 64'd16);
        chk("zero lanes16", b16.out_data, 64'hCCCCCCCCCCCCCCCC);
        chk("zero lanes1", b1.out_data, 64'hCCCCCCCCCCCCCCCC);
        chk("zero lanes4", b4.out_data, 64'hCCCCCCCCCCCCCCCC);
        ordy = 1'b1;
        @(posedge clk); #1;
        chk("zero l1 back idle", {63'd0, b1.in_ready}, 64'd1);

        // Back-pressure, then in_valid coinciding with the output handshake.
        wait_idle_all();
        ordy = 1'b0;
        iv = 1'b1;
        id = 64'h0123456789ABCDEF;
        im = 1'b0;
        @(posedge clk); #1;
        iv = 1'b0;
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("bp out_valid", {63'd0, b4.out_valid}, 64'd1);
        r0 = b4.out_data;
        chk("bp data", r0, 64'hC56B90AD3EF84712);
        bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (b4.out_data !== r0 || !b4.out_valid || b4.in_ready) bad++;
        end
        chk("bp held stable", 64'(bad), 64'd0);
        iv = 1'b1;
        id = 64'hFFFFFFFFFFFFFFFF;
        im = 1'b1;
        ordy = 1'b1;
        @(posedge clk); #1;
        chk("bp release in_ready", {63'd0, b4.in_ready}, 64'd1);
        chk("bp release out_valid", {63'd0, b4.out_valid}, 64'd0);
        chk("bp release busy", {63'd0, b4.busy}, 64'd0);
        @(posedge clk); #1;
        iv = 1'b0;
        chk("accept after idle", {63'd0, b4.busy}, 64'd1);
        repeat (4) begin
            @(posedge clk); #1;
        end
        chk("post-bp out_valid", {63'd0, b4.out_valid}, 64'd1);
        chk("post-bp data", b4.out_data, 64'hAAAAAAAAAAAAAAAA);
        @(posedge clk); #1;

        // Asynchronous reset two steps into BUSY.
        wait_idle_all();
        iv = 1'b1;
        id = 64'h0123456789ABCDEF;
        im = 1'b0;
        @(posedge clk); #1;
        iv = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre-reset busy", {63'd0, b4.busy}, 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("mid-rst in_ready", {63'd0, b4.in_ready}, 64'd1);
        chk("mid-rst out_valid", {63'd0, b4.out_valid}, 64'd0);
        chk("mid-rst busy", {63'd0, b4.busy}, 64'd0);
        chk("mid-rst out_data", b4.out_data, 64'd0);
        #1 reset_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk); #1;
            if (b4.out_valid) bad++;
        end
        chk("no stale out_valid", 64'(bad), 64'd0);
        run_word(64'hFFFFFFFFFFFFFFFF, 1'b0, res, lat);
        chk("post-rst data", res, 64'h2222222222222222);
        chk("post-rst latency", 64'(lat), 64'd4);

        // Random stream with random out_ready, scoreboarded in order.
        wait_idle_all();
        sent = 0;
        got = 0;
        acc = 1'b0;
        bad = 0;
        for (int c = 0; c < 400 && got < 8; c++) begin
            @(negedge clk);
            if (acc) begin
                iv = 1'b0;
                acc = 1'b0;
            end
            ordy = 1'($urandom_range(0, 1));
            if (b4.out_valid && ordy) begin
                if (q.size() == 0) begin
                    chk("stream extra output", 64'd1, 64'd0);
                end else begin
                    chk($sformatf("stream word %0d", got), b4.out_data,
                        q.pop_front());
                end
                got++;
            end
            if (!iv && sent < 8) begin
                iv = 1'b1;
                id = {$urandom, $urandom};
                im = 1'($urandom_range(0, 1));
            end
            if (iv && b4.in_ready) begin
                q.push_back(model(id, im));
                sent++;
                acc = 1'b1;
            end
        end
        @(negedge clk);
        iv = 1'b0;
        chk("stream sent", 64'(sent), 64'd8);
        chk("stream received", 64'(got), 64'd8);
        chk("stream leftover", 64'(q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
